// File: rtl/msrv_32_pkg.sv
// rtl/msrv_32_pkg.sv - msrv_32 opcode classes, control-field encodings and the decoded bundle type
package msrv_32_pkg;

    // opcode[6:2] class codes
    localparam logic [4:0] OPC_BRANCH   = 5'b11000;
    localparam logic [4:0] OPC_JAL      = 5'b11011;
    localparam logic [4:0] OPC_JALR     = 5'b11001;
    localparam logic [4:0] OPC_AUIPC    = 5'b00101;
    localparam logic [4:0] OPC_LUI      = 5'b01101;
    localparam logic [4:0] OPC_OP       = 5'b01100;
    localparam logic [4:0] OPC_OP_IMM   = 5'b00100;
    localparam logic [4:0] OPC_LOAD     = 5'b00000;
    localparam logic [4:0] OPC_STORE    = 5'b01000;
    localparam logic [4:0] OPC_SYSTEM   = 5'b11100;
    localparam logic [4:0] OPC_MISC_MEM = 5'b00011;

    localparam logic [2:0] WB_ALU       = 3'b000;
    localparam logic [2:0] WB_LOAD      = 3'b001;
    localparam logic [2:0] WB_IMM       = 3'b010;
    localparam logic [2:0] WB_IADDER    = 3'b011;
    localparam logic [2:0] WB_CSR       = 3'b100;
    localparam logic [2:0] WB_PC_PLUS_4 = 3'b101;

    localparam logic [2:0] IMM_NONE     = 3'b000;
    localparam logic [2:0] IMM_I        = 3'b001;
    localparam logic [2:0] IMM_S        = 3'b010;
    localparam logic [2:0] IMM_B        = 3'b011;
    localparam logic [2:0] IMM_U        = 3'b100;
    localparam logic [2:0] IMM_J        = 3'b101;
    localparam logic [2:0] IMM_CSR      = 3'b110;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  funct3;
        logic [2:0]  wb_mux_sel;
        logic [2:0]  imm_type;
        logic [3:0]  alu_opcode;
        logic [2:0]  csr_op;
        logic        alu_src;
        logic        iadder_src;
        logic        csr_wr_en;
        logic        rf_wr_en;
        logic        mem_wr_req;
        logic        is_load;
        logic        is_branch;
        logic        is_muldiv;
        logic        illegal;
    } dec_bundle_t;

endpackage

// File: rtl/msrv_32_decode_comb.sv
// rtl/msrv_32_decode_comb.sv - combinational instruction decode into dec_bundle_t (RV32M via MSRV_RV32M_EN)
module msrv_32_decode_comb
    import msrv_32_pkg::*;
(
    input  logic [31:0]  instr_in,
    input  logic [31:0]  pc_in,
    input  logic         trap_taken_in,
    output dec_bundle_t  bundle_out
);

    logic [4:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;
    logic is_branch, is_jal, is_jalr, is_auipc, is_lui, is_op, is_op_imm;
    logic is_load, is_store, is_system, is_misc_mem, any_cls;
    logic muldiv_enc, op_legal, shift_legal, illegal, is_csr;

    assign opc = instr_in[6:2];
    assign f3  = instr_in[14:12];
    assign f7  = instr_in[31:25];

    assign is_branch   = (opc == OPC_BRANCH);
    assign is_jal      = (opc == OPC_JAL);
    assign is_jalr     = (opc == OPC_JALR);
    assign is_auipc    = (opc == OPC_AUIPC);
    assign is_lui      = (opc == OPC_LUI);
    assign is_op       = (opc == OPC_OP);
    assign is_op_imm   = (opc == OPC_OP_IMM);
    assign is_load     = (opc == OPC_LOAD);
    assign is_store    = (opc == OPC_STORE);
    assign is_system   = (opc == OPC_SYSTEM);
    assign is_misc_mem = (opc == OPC_MISC_MEM);
    assign any_cls     = is_branch | is_jal | is_jalr | is_auipc | is_lui | is_op | is_op_imm
                       | is_load | is_store | is_system | is_misc_mem;

`ifdef MSRV_RV32M_EN
    assign muldiv_enc = is_op & (f7 == 7'b0000001);
`else
    assign muldiv_enc = 1'b0;
`endif

    // Only ADD/SUB and SRL/SRA have a funct7=0100000 variant
    assign op_legal    = (f7 == 7'b0000000)
                       | ((f7 == 7'b0100000) & ((f3 == 3'b000) | (f3 == 3'b101)))
                       | muldiv_enc;
    assign shift_legal = (f3 == 3'b001) ? (f7 == 7'b0000000) :
                         (f3 == 3'b101) ? ((f7 == 7'b0000000) | (f7 == 7'b0100000)) : 1'b1;
    assign illegal     = (instr_in[1:0] != 2'b11) | !any_cls
                       | (is_op & !op_legal) | (is_op_imm & !shift_legal);
    assign is_csr      = is_system & (f3 != 3'b000);

    always_comb begin
        bundle_out            = '0;
        bundle_out.pc         = pc_in;
        bundle_out.rd         = instr_in[11:7];
        bundle_out.rs1        = instr_in[19:15];
        bundle_out.rs2        = instr_in[24:20];
        bundle_out.funct3     = f3;
        bundle_out.wb_mux_sel = {is_csr | is_jal | is_jalr, is_lui | is_auipc,
                                 is_load | is_auipc | is_jal | is_jalr};
        bundle_out.imm_type   = {is_lui | is_auipc | is_jal | is_csr, is_store | is_branch | is_csr,
                                 is_op_imm | is_load | is_jalr | is_branch | is_jal};
        bundle_out.alu_opcode = {((is_op & !muldiv_enc) | (is_op_imm & (f3 == 3'b101))) & instr_in[30], f3};
        bundle_out.csr_op     = is_csr ? f3 : 3'b000;
        bundle_out.alu_src    = instr_in[5];
        bundle_out.iadder_src = is_load | is_store | is_jalr;
        bundle_out.csr_wr_en  = is_csr & !illegal;
        bundle_out.rf_wr_en   = (is_lui | is_auipc | is_jal | is_jalr | is_op | is_op_imm | is_load | is_csr)
                              & !illegal;
        bundle_out.mem_wr_req = is_store & !trap_taken_in & !illegal;
        bundle_out.is_load    = is_load;
        bundle_out.is_branch  = is_branch;
        bundle_out.is_muldiv  = muldiv_enc & !illegal;
        bundle_out.illegal    = illegal;
    end

endmodule

// File: rtl/msrv_32_decode_stage.sv
// rtl/msrv_32_decode_stage.sv - msrv_32 decode stage: bundle FIFO, handshake, flush, illegal counter (MSRV_RV32M_EN)
module msrv_32_decode_stage
    import msrv_32_pkg::*;
#(
    parameter int DEPTH  = 2,
    parameter int PC_W   = 32,
    parameter int ICNT_W = 16
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              instr_valid_in,
    output logic              instr_ready_out,
    input  logic [31:0]       instr_in,
    input  logic [PC_W-1:0]   pc_in,
    input  logic              flush_in,
    input  logic              trap_taken_in,
    output logic              dec_valid_out,
    input  logic              dec_ready_in,
    output logic [PC_W-1:0]   pc_out,
    output logic [4:0]        rd_out,
    output logic [4:0]        rs1_out,
    output logic [4:0]        rs2_out,
    output logic [2:0]        funct3_out,
    output logic [2:0]        wb_mux_sel_out,
    output logic [2:0]        imm_type_out,
    output logic [3:0]        alu_opcode_out,
    output logic [2:0]        csr_op_out,
    output logic              alu_src_out,
    output logic              iadder_src_out,
    output logic              csr_wr_en_out,
    output logic              rf_wr_en_out,
    output logic              mem_wr_req_out,
    output logic              is_load_out,
    output logic              is_branch_out,
    output logic              is_muldiv_out,
    output logic              illegal_instr_out,
    output logic [ICNT_W-1:0] illegal_cnt_out
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    dec_bundle_t dec_bundle;
    dec_bundle_t head;
    dec_bundle_t mem_q [DEPTH];
    dec_bundle_t mem_d [DEPTH];

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [ICNT_W-1:0] illegal_cnt_q, illegal_cnt_d;
    logic              ready_q, ready_d;
    logic              push, pop;

    msrv_32_decode_comb u_decode_comb (
        .instr_in      (instr_in),
        .pc_in         (32'(pc_in)),
        .trap_taken_in (trap_taken_in),
        .bundle_out    (dec_bundle)
    );

    assign push = instr_valid_in & ready_q & !flush_in;
    assign pop  = (count_q != '0) & dec_ready_in & !flush_in;

    always_comb begin
        mem_d         = mem_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        count_d       = count_q;
        illegal_cnt_d = illegal_cnt_q;
        if (flush_in) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = dec_bundle;
                wr_ptr_d        = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
        if (push && dec_bundle.illegal && !(&illegal_cnt_q)) begin
            illegal_cnt_d = illegal_cnt_q + 1'b1;
        end
        // Ready follows next-cycle occupancy, so a pop while full re-opens it only a cycle later
        ready_d = (count_d != CNT_W'(DEPTH));
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            illegal_cnt_q <= '0;
            ready_q       <= 1'b1;
        end else begin
            mem_q         <= mem_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            illegal_cnt_q <= illegal_cnt_d;
            ready_q       <= ready_d;
        end
    end

    assign head              = mem_q[rd_ptr_q];
    assign instr_ready_out   = ready_q;
    assign dec_valid_out     = (count_q != '0);
    assign illegal_cnt_out   = illegal_cnt_q;
    assign pc_out            = head.pc[PC_W-1:0];
    assign rd_out            = head.rd;
    assign rs1_out           = head.rs1;
    assign rs2_out           = head.rs2;
    assign funct3_out        = head.funct3;
    assign wb_mux_sel_out    = head.wb_mux_sel;
    assign imm_type_out      = head.imm_type;
    assign alu_opcode_out    = head.alu_opcode;
    assign csr_op_out        = head.csr_op;
    assign alu_src_out       = head.alu_src;
    assign iadder_src_out    = head.iadder_src;
    assign csr_wr_en_out     = head.csr_wr_en;
    assign rf_wr_en_out      = head.rf_wr_en;
    assign mem_wr_req_out    = head.mem_wr_req;
    assign is_load_out       = head.is_load;
    assign is_branch_out     = head.is_branch;
    assign is_muldiv_out     = head.is_muldiv;
    assign illegal_instr_out = head.illegal;

endmodule

// File: tb/tb_msrv_32_decode_stage.sv
// tb/tb_msrv_32_decode_stage.sv - directed and random bench for msrv_32_decode_stage against a queue model
module tb_msrv_32_decode_stage;
    import msrv_32_pkg::*;

    localparam int DEPTH  = 2;
    localparam int PC_W   = 32;
    localparam int ICNT_W = 4;
    localparam logic [ICNT_W-1:0] CNT_MAX = '1;

    logic clk_in = 1'b0;
    logic rst_in = 1'b1;
    logic instr_valid_in = 1'b0, flush_in = 1'b0, trap_taken_in = 1'b0, dec_ready_in = 1'b0;
    logic [31:0] instr_in = '0;
    logic [PC_W-1:0] pc_in = '0;
    logic instr_ready_out, dec_valid_out;
    logic [PC_W-1:0] pc_out;
    logic [4:0] rd_out, rs1_out, rs2_out;
    logic [2:0] funct3_out, wb_mux_sel_out, imm_type_out, csr_op_out;
    logic [3:0] alu_opcode_out;
    logic alu_src_out, iadder_src_out, csr_wr_en_out, rf_wr_en_out, mem_wr_req_out;
    logic is_load_out, is_branch_out, is_muldiv_out, illegal_instr_out;
    logic [ICNT_W-1:0] illegal_cnt_out;

    int n_checks = 0;
    int n_errors = 0;
    dec_bundle_t exp_q[$];
    logic [ICNT_W-1:0] exp_cnt = '0;

    msrv_32_decode_stage #(.DEPTH(DEPTH), .PC_W(PC_W), .ICNT_W(ICNT_W)) dut (
        .clk_in(clk_in), .rst_in(rst_in),
        .instr_valid_in(instr_valid_in), .instr_ready_out(instr_ready_out),
        .instr_in(instr_in), .pc_in(pc_in), .flush_in(flush_in), .trap_taken_in(trap_taken_in),
        .dec_valid_out(dec_valid_out), .dec_ready_in(dec_ready_in), .pc_out(pc_out),
        .rd_out(rd_out), .rs1_out(rs1_out), .rs2_out(rs2_out), .funct3_out(funct3_out),
        .wb_mux_sel_out(wb_mux_sel_out), .imm_type_out(imm_type_out),
        .alu_opcode_out(alu_opcode_out), .csr_op_out(csr_op_out),
        .alu_src_out(alu_src_out), .iadder_src_out(iadder_src_out),
        .csr_wr_en_out(csr_wr_en_out), .rf_wr_en_out(rf_wr_en_out),
        .mem_wr_req_out(mem_wr_req_out), .is_load_out(is_load_out),
        .is_branch_out(is_branch_out), .is_muldiv_out(is_muldiv_out),
        .illegal_instr_out(illegal_instr_out), .illegal_cnt_out(illegal_cnt_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference decode written per instruction class
    function automatic dec_bundle_t ref_decode(input logic [31:0] i, input logic [31:0] pc, input logic trap);
        dec_bundle_t b;
        logic [2:0] f3;
        logic [6:0] f7;
        logic ok, wr, csr;
        f3 = i[14:12];
        f7 = i[31:25];
        b = '0;
        b.pc = pc; b.rd = i[11:7]; b.rs1 = i[19:15]; b.rs2 = i[24:20]; b.funct3 = f3;
        b.alu_src = i[5];
        b.alu_opcode = {1'b0, f3};
        ok = (i[1:0] == 2'b11);
        wr = 1'b0;
        csr = 1'b0;
        case (i[6:2])
            OPC_LUI:    begin wr = 1'b1; b.wb_mux_sel = WB_IMM; b.imm_type = IMM_U; end
            OPC_AUIPC:  begin wr = 1'b1; b.wb_mux_sel = WB_IADDER; b.imm_type = IMM_U; end
            OPC_JAL:    begin wr = 1'b1; b.wb_mux_sel = WB_PC_PLUS_4; b.imm_type = IMM_J; end
            OPC_JALR:   begin wr = 1'b1; b.wb_mux_sel = WB_PC_PLUS_4; b.imm_type = IMM_I; b.iadder_src = 1'b1; end
            OPC_BRANCH: begin b.imm_type = IMM_B; b.is_branch = 1'b1; end
            OPC_LOAD:   begin wr = 1'b1; b.wb_mux_sel = WB_LOAD; b.imm_type = IMM_I;
                              b.is_load = 1'b1; b.iadder_src = 1'b1; end
            OPC_STORE:  begin b.imm_type = IMM_S; b.iadder_src = 1'b1; b.mem_wr_req = !trap; end
            OPC_OP_IMM: begin
                wr = 1'b1; b.imm_type = IMM_I;
                if (f3 == 3'b101) b.alu_opcode[3] = i[30];
                if (f3 == 3'b001 && f7 != 7'h00) ok = 1'b0;
                if (f3 == 3'b101 && f7 != 7'h00 && f7 != 7'h20) ok = 1'b0;
            end
            OPC_OP: begin
                wr = 1'b1;
                if (f7 == 7'h20) begin
                    b.alu_opcode[3] = 1'b1;
                    if (f3 != 3'b000 && f3 != 3'b101) ok = 1'b0;
                end else if (f7 == 7'h01) begin
`ifdef MSRV_RV32M_EN
                    b.is_muldiv = 1'b1;
`else
                    ok = 1'b0;
`endif
                end else if (f7 != 7'h00) begin
                    ok = 1'b0;
                end
            end
            OPC_SYSTEM: if (f3 != 3'b000) begin
                csr = 1'b1; wr = 1'b1; b.wb_mux_sel = WB_CSR; b.imm_type = IMM_CSR; b.csr_op = f3;
            end
            OPC_MISC_MEM: ;
            default: ok = 1'b0;
        endcase
        b.illegal    = !ok;
        b.rf_wr_en   = wr & ok;
        b.csr_wr_en  = csr & ok;
        b.mem_wr_req = b.mem_wr_req & ok;
        b.is_muldiv  = b.is_muldiv & ok;
        return b;
    endfunction

    task automatic check_head(input dec_bundle_t e);
        check_eq("pc", pc_out, e.pc);
        check_eq("illegal", illegal_instr_out, e.illegal);
        check_eq("rf_wr_en", rf_wr_en_out, e.rf_wr_en);
        check_eq("csr_wr_en", csr_wr_en_out, e.csr_wr_en);
        check_eq("mem_wr_req", mem_wr_req_out, e.mem_wr_req);
        if (!e.illegal) begin
            check_eq("regs", {rd_out, rs1_out, rs2_out, funct3_out}, {e.rd, e.rs1, e.rs2, e.funct3});
            check_eq("wb_mux_sel", wb_mux_sel_out, e.wb_mux_sel);
            check_eq("imm_type", imm_type_out, e.imm_type);
            check_eq("alu_opcode", alu_opcode_out, e.alu_opcode);
            check_eq("csr_op", csr_op_out, e.csr_op);
            check_eq("flags", {alu_src_out, iadder_src_out, is_load_out, is_branch_out, is_muldiv_out},
                     {e.alu_src, e.iadder_src, e.is_load, e.is_branch, e.is_muldiv});
        end
    endtask

    task automatic step(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                        input logic fl, input logic tr, input logic rdy);
        dec_bundle_t e;
        logic do_push, do_pop;
        instr_valid_in = v; instr_in = ins; pc_in = pc;
        flush_in = fl; trap_taken_in = tr; dec_ready_in = rdy;
        e = ref_decode(ins, pc, tr);
        do_push = v && (exp_q.size() < DEPTH) && !fl;
        do_pop  = (exp_q.size() > 0) && rdy && !fl;
        if (do_push && e.illegal && exp_cnt != CNT_MAX) exp_cnt++;
        if (fl) begin
            exp_q.delete();
        end else begin
            if (do_pop) void'(exp_q.pop_front());
            if (do_push) exp_q.push_back(e);
        end
        @(negedge clk_in);
        check_eq("instr_ready", instr_ready_out, exp_q.size() < DEPTH);
        check_eq("dec_valid", dec_valid_out, exp_q.size() != 0);
        check_eq("illegal_cnt", illegal_cnt_out, exp_cnt);
        if (exp_q.size() != 0) check_head(exp_q[0]);
    endtask

    task automatic idle(input logic rdy);
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, rdy);
    endtask

    task automatic drain();
        repeat (DEPTH + 1) idle(1'b1);
    endtask

    task automatic do_reset();
        instr_valid_in = 1'b0; flush_in = 1'b0; trap_taken_in = 1'b0; dec_ready_in = 1'b0;
        rst_in = 1'b1;
        exp_q.delete();
        exp_cnt = '0;
        repeat (2) @(negedge clk_in);
        check_eq("rst_valid", dec_valid_out, 1'b0);
        check_eq("rst_ready", instr_ready_out, 1'b1);
        check_eq("rst_cnt", illegal_cnt_out, '0);
        check_eq("rst_bundle", {pc_out, rf_wr_en_out, mem_wr_req_out, illegal_instr_out, wb_mux_sel_out}, '0);
        rst_in = 1'b0;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] i;
        i = $urandom();
        if ($urandom_range(0, 7) != 0) begin
            case ($urandom_range(0, 10))
                0: i[6:2] = OPC_BRANCH;   1: i[6:2] = OPC_JAL;     2: i[6:2] = OPC_JALR;
                3: i[6:2] = OPC_AUIPC;    4: i[6:2] = OPC_LUI;     5: i[6:2] = OPC_OP;
                6: i[6:2] = OPC_OP_IMM;   7: i[6:2] = OPC_LOAD;    8: i[6:2] = OPC_STORE;
                9: i[6:2] = OPC_SYSTEM;   default: i[6:2] = OPC_MISC_MEM;
            endcase
            if ($urandom_range(0, 9) != 0) i[1:0] = 2'b11;
            case ($urandom_range(0, 3))
                0: i[31:25] = 7'h00;
                1: i[31:25] = 7'h20;
                2: i[31:25] = 7'h01;
                default: ;
            endcase
        end
        return i;
    endfunction

    localparam logic [31:0] I_ADDI = 32'h0050_0093;
    localparam logic [31:0] I_SW   = 32'h0020_a023;
    localparam logic [31:0] I_MUL  = 32'h0220_81b3;

    initial begin
        do_reset();

        // ADDI x1,x0,5 visible the cycle after acceptance
        step(1'b1, I_ADDI, 32'h100, 1'b0, 1'b0, 1'b0);
        check_eq("addi_valid", dec_valid_out, 1'b1);
        check_eq("addi_rf", rf_wr_en_out, 1'b1);
        check_eq("addi_imm", imm_type_out, 3'b001);
        check_eq("addi_alu", alu_opcode_out, 4'b0000);
        check_eq("addi_wb", wb_mux_sel_out, 3'b000);
        check_eq("addi_rd", rd_out, 5'd1);
        drain();

        // Back-pressure: third instruction waits for a pop plus one cycle
        step(1'b1, 32'h0000_0013, 32'h200, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h0010_0113, 32'h204, 1'b0, 1'b0, 1'b0);
        check_eq("full_ready", instr_ready_out, 1'b0);
        step(1'b1, 32'h0020_0193, 32'h208, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h0020_0193, 32'h208, 1'b0, 1'b0, 1'b1);
        check_eq("pop_head_pc", pc_out, 32'h204);
        step(1'b1, 32'h0020_0193, 32'h208, 1'b0, 1'b0, 1'b0);
        drain();

        // Flush while full with a valid input pending
        step(1'b1, 32'h0000_0013, 32'h300, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h0000_0013, 32'h304, 1'b0, 1'b0, 1'b0);
        step(1'b1, 32'h0000_0013, 32'h308, 1'b1, 1'b0, 1'b0);
        check_eq("flush_valid", dec_valid_out, 1'b0);
        idle(1'b1);
        idle(1'b1);

        // Illegal instructions and counter saturation
        step(1'b1, 32'hffff_ffff, 32'h400, 1'b0, 1'b0, 1'b1);
        check_eq("ill_ff_flag", illegal_instr_out, 1'b1);
        step(1'b1, 32'h0000_0000, 32'h404, 1'b0, 1'b0, 1'b1);
        check_eq("ill_00_flag", illegal_instr_out, 1'b1);
        check_eq("ill_00_wr", {rf_wr_en_out, csr_wr_en_out, mem_wr_req_out}, 3'b000);
        check_eq("cnt_two", illegal_cnt_out, 4'd2);
        repeat (13) step(1'b1, 32'hffff_ffff, 32'h408, 1'b0, 1'b0, 1'b1);
        check_eq("cnt_full", illegal_cnt_out, 4'd15);
        step(1'b1, 32'h0000_0000, 32'h40c, 1'b0, 1'b0, 1'b1);
        check_eq("cnt_sat", illegal_cnt_out, 4'd15);
        drain();

        // Store with and without a trap at push
        step(1'b1, I_SW, 32'h500, 1'b0, 1'b1, 1'b0);
        check_eq("sw_trap", mem_wr_req_out, 1'b0);
        idle(1'b1);
        step(1'b1, I_SW, 32'h504, 1'b0, 1'b0, 1'b0);
        check_eq("sw_notrap", mem_wr_req_out, 1'b1);
        drain();

        step(1'b1, I_MUL, 32'h600, 1'b0, 1'b0, 1'b0);
`ifdef MSRV_RV32M_EN
        check_eq("mul_muldiv", is_muldiv_out, 1'b1);
        check_eq("mul_illegal", illegal_instr_out, 1'b0);
`else
        check_eq("mul_muldiv", is_muldiv_out, 1'b0);
        check_eq("mul_illegal", illegal_instr_out, 1'b1);
`endif
        drain();

        do_reset();
        for (int n = 0; n < 3000; n++) begin
            step($urandom_range(0, 3) != 0, rand_instr(), $urandom(),
                 $urandom_range(0, 15) == 0, $urandom_range(0, 7) == 0,
                 $urandom_range(0, 2) != 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
